// File: rtl/regset_bus_sequencer.sv
// regset_bus_sequencer
//   Sequences src->dst moves on the shared 8-bit bus between the two-register set and the
//   immediate driver. Two requesters are arbitrated round-robin through a valid/ready
//   handshake. Each move runs IDLE -> DRIVE -> WRITE -> TURN (TURN_CYCLES, skipped if 0).
//   All strobes are registered, so only one bus driver is ever enabled in any cycle.
//
// Ports
//   i_clk, i_nReset               clock, synchronous active-low reset
//   i_reqNValid/Src/Dst           requester N move: src 0=reg0 1=reg1 2=imm 3=none,
//                                 dst mask bit0=reg0 bit1=reg1
//   o_reqNReady                   requester N accepted this cycle (combinational)
//   i_aluSelWe, i_aluSel          load the ALU operand select
//   o_ctrlReg{0,1}NWE             register write enables, active low
//   o_ctrlReg{0,1}BusNOE          register bus drives, active low
//   o_ctrlImmBusNOE               immediate bus drive, active low
//   o_ctrlAluSel                  registered ALU operand select
//   o_busy                        sequencer not idle
//   o_grant                       requester owning the current or last move

module regset_bus_sequencer #(
   parameter int unsigned TURN_CYCLES = 1  // legal 0..3
) (
   input  logic       i_clk,
   input  logic       i_nReset,
   input  logic       i_req0Valid,
   input  logic [1:0] i_req0Src,
   input  logic [1:0] i_req0Dst,
   output logic       o_req0Ready,
   input  logic       i_req1Valid,
   input  logic [1:0] i_req1Src,
   input  logic [1:0] i_req1Dst,
   output logic       o_req1Ready,
   input  logic       i_aluSelWe,
   input  logic       i_aluSel,
   output logic       o_ctrlReg0NWE,
   output logic       o_ctrlReg1NWE,
   output logic       o_ctrlReg0BusNOE,
   output logic       o_ctrlReg1BusNOE,
   output logic       o_ctrlImmBusNOE,
   output logic       o_ctrlAluSel,
   output logic       o_busy,
   output logic       o_grant
);

   typedef enum logic [1:0] {StIdle, StDrive, StWrite, StTurn} state_e;

   localparam logic [1:0] SrcNone  = 2'd3;
   // Counter load for the TURN phase; unused when TURN_CYCLES is 0.
   localparam logic [1:0] TurnLast = (TURN_CYCLES == 0) ? 2'd0 : 2'(TURN_CYCLES - 1);

   state_e     state_q;
   logic [1:0] src_q;
   logic [1:0] dst_q;
   logic [1:0] turn_cnt_q;
   logic       rr_q;         // requester that wins the next tie
   logic       grant_q;
   logic       alu_sel_q;
   logic       reg0_nwe_q;
   logic       reg1_nwe_q;
   logic       reg0_noe_q;
   logic       reg1_noe_q;
   logic       imm_noe_q;

   logic       gnt_sel;
   logic       accept;
   logic [1:0] acc_src;
   logic [1:0] acc_dst;
   logic       write_en;

   // Arbitration: a lone requester wins; a tie goes to the round-robin pointer.
   always_comb begin
      gnt_sel = 1'b0;
      if (i_req0Valid && i_req1Valid) begin
         gnt_sel = rr_q;
      end else if (i_req1Valid) begin
         gnt_sel = 1'b1;
      end
   end

   assign o_req0Ready = (state_q == StIdle) & i_req0Valid & ~gnt_sel;
   assign o_req1Ready = (state_q == StIdle) & i_req1Valid &  gnt_sel;
   assign accept      = o_req0Ready | o_req1Ready;
   assign acc_src     = gnt_sel ? i_req1Src : i_req0Src;
   assign acc_dst     = gnt_sel ? i_req1Dst : i_req0Dst;
   // A move with no source still takes full timing but must never write.
   assign write_en    = (src_q != SrcNone);

   always_ff @(posedge i_clk) begin
      if (!i_nReset) begin
         state_q    <= StIdle;
         src_q      <= SrcNone;
         dst_q      <= 2'b00;
         turn_cnt_q <= 2'd0;
         rr_q       <= 1'b0;
         grant_q    <= 1'b0;
         alu_sel_q  <= 1'b0;
         reg0_nwe_q <= 1'b1;
         reg1_nwe_q <= 1'b1;
         reg0_noe_q <= 1'b1;
         reg1_noe_q <= 1'b1;
         imm_noe_q  <= 1'b1;
      end else begin
         if (i_aluSelWe) begin
            alu_sel_q <= i_aluSel;
         end
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  src_q      <= acc_src;
                  dst_q      <= acc_dst;
                  grant_q    <= gnt_sel;
                  rr_q       <= ~gnt_sel;
                  reg0_noe_q <= (acc_src != 2'd0);
                  reg1_noe_q <= (acc_src != 2'd1);
                  imm_noe_q  <= (acc_src != 2'd2);
                  state_q    <= StDrive;
               end
            end
            StDrive: begin
               // Source keeps driving; destinations strobe during WRITE.
               reg0_nwe_q <= ~(write_en & dst_q[0]);
               reg1_nwe_q <= ~(write_en & dst_q[1]);
               state_q    <= StWrite;
            end
            StWrite: begin
               reg0_nwe_q <= 1'b1;
               reg1_nwe_q <= 1'b1;
               reg0_noe_q <= 1'b1;
               reg1_noe_q <= 1'b1;
               imm_noe_q  <= 1'b1;
               turn_cnt_q <= TurnLast;
               state_q    <= (TURN_CYCLES == 0) ? StIdle : StTurn;
            end
            StTurn: begin
               if (turn_cnt_q == 2'd0) begin
                  state_q <= StIdle;
               end else begin
                  turn_cnt_q <= turn_cnt_q - 2'd1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign o_ctrlReg0NWE    = reg0_nwe_q;
   assign o_ctrlReg1NWE    = reg1_nwe_q;
   assign o_ctrlReg0BusNOE = reg0_noe_q;
   assign o_ctrlReg1BusNOE = reg1_noe_q;
   assign o_ctrlImmBusNOE  = imm_noe_q;
   assign o_ctrlAluSel     = alu_sel_q;
   assign o_busy           = (state_q != StIdle);
   assign o_grant          = grant_q;

endmodule

// File: tb/tb_regset_bus_sequencer.sv
// Self-checking bench for regset_bus_sequencer. Expected moves are queued when requests are
// driven and compared as the sequencer plays them out on its strobes. Two extra instances
// (TURN_CYCLES 0 and 3) check back-to-back accept periods.

module tb_regset_bus_sequencer;

   localparam int unsigned Turn = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       n_reset;
   logic       v0, v1;
   logic [1:0] s0, d0, s1, d1;
   logic       alu_we, alu_sel;
   logic       r0, r1, w0n, w1n, o0n, o1n, oin, alu_o, busy, grant;

   regset_bus_sequencer #(.TURN_CYCLES(Turn)) u_dut (
      .i_clk(clk), .i_nReset(n_reset),
      .i_req0Valid(v0), .i_req0Src(s0), .i_req0Dst(d0), .o_req0Ready(r0),
      .i_req1Valid(v1), .i_req1Src(s1), .i_req1Dst(d1), .o_req1Ready(r1),
      .i_aluSelWe(alu_we), .i_aluSel(alu_sel),
      .o_ctrlReg0NWE(w0n), .o_ctrlReg1NWE(w1n),
      .o_ctrlReg0BusNOE(o0n), .o_ctrlReg1BusNOE(o1n), .o_ctrlImmBusNOE(oin),
      .o_ctrlAluSel(alu_o), .o_busy(busy), .o_grant(grant)
   );

   // Period instances: requester 0 only, held valid continuously.
   logic       pv;
   logic       ra, rb, ra1, rb1;
   logic [4:0] sa, sb_s;   // {noe imm,r1,r0, nwe r1,r0}
   logic [2:0] xa, xb;     // alu, busy, grant

   regset_bus_sequencer #(.TURN_CYCLES(0)) u_dut_t0 (
      .i_clk(clk), .i_nReset(n_reset),
      .i_req0Valid(pv), .i_req0Src(2'd2), .i_req0Dst(2'd3), .o_req0Ready(ra),
      .i_req1Valid(1'b0), .i_req1Src(2'd0), .i_req1Dst(2'd0), .o_req1Ready(ra1),
      .i_aluSelWe(1'b0), .i_aluSel(1'b0),
      .o_ctrlReg0NWE(sa[0]), .o_ctrlReg1NWE(sa[1]),
      .o_ctrlReg0BusNOE(sa[2]), .o_ctrlReg1BusNOE(sa[3]), .o_ctrlImmBusNOE(sa[4]),
      .o_ctrlAluSel(xa[0]), .o_busy(xa[1]), .o_grant(xa[2])
   );

   regset_bus_sequencer #(.TURN_CYCLES(3)) u_dut_t3 (
      .i_clk(clk), .i_nReset(n_reset),
      .i_req0Valid(pv), .i_req0Src(2'd0), .i_req0Dst(2'd2), .o_req0Ready(rb),
      .i_req1Valid(1'b0), .i_req1Src(2'd0), .i_req1Dst(2'd0), .o_req1Ready(rb1),
      .i_aluSelWe(1'b0), .i_aluSel(1'b0),
      .o_ctrlReg0NWE(sb_s[0]), .o_ctrlReg1NWE(sb_s[1]),
      .o_ctrlReg0BusNOE(sb_s[2]), .o_ctrlReg1BusNOE(sb_s[3]), .o_ctrlImmBusNOE(sb_s[4]),
      .o_ctrlAluSel(xb[0]), .o_busy(xb[1]), .o_grant(xb[2])
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic       g;
      logic [2:0] noe;   // {imm, reg1, reg0}
      logic [1:0] nwe;   // {reg1, reg0}
   } xfer_t;

   xfer_t sb[$];
   xfer_t cur;

   function automatic xfer_t mk(input logic g, input logic [1:0] src, input logic [1:0] dst);
      xfer_t x;
      x.g   = g;
      x.noe = 3'b111;
      if (src != 2'd3) x.noe[src] = 1'b0;
      x.nwe = (src == 2'd3) ? 2'b11 : ~dst;
      return x;
   endfunction

   // Monitor: plays each busy window against the next queued move.
   logic mon_en   = 1'b0;
   logic busy_prv = 1'b0;
   logic rst_seen = 1'b0;
   int   k        = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("noe_excl", 32'($countones(~{oin, o1n, o0n}) <= 1), 1);
         check("rdy_excl", 32'(r0 & r1), 0);
         if (busy) begin
            if (!busy_prv) begin
               k = 0;
               rst_seen = 1'b0;
               if (sb.size() == 0) begin
                  check("unexpected_xfer", 1, 0);
                  cur = mk(grant, 2'd3, 2'd0);
               end else begin
                  cur = sb.pop_front();
               end
               check("drive_noe", {29'd0, oin, o1n, o0n}, {29'd0, cur.noe});
               check("drive_nwe", {30'd0, w1n, w0n}, 32'd3);
               check("drive_grant", {31'd0, grant}, {31'd0, cur.g});
            end else begin
               k++;
            end
            if (k == 1) begin
               check("write_noe", {29'd0, oin, o1n, o0n}, {29'd0, cur.noe});
               check("write_nwe", {30'd0, w1n, w0n}, {30'd0, cur.nwe});
            end else if (k >= 2) begin
               check("turn_strobes", {27'd0, oin, o1n, o0n, w1n, w0n}, 32'h1f);
            end
            if (!n_reset) rst_seen = 1'b1;
         end else begin
            check("idle_strobes", {27'd0, oin, o1n, o0n, w1n, w0n}, 32'h1f);
            if (busy_prv && !rst_seen) check("busy_len", k + 1, 2 + Turn);
         end
         busy_prv = busy;
      end
   end

   task automatic step(input logic e0, input logic e1);
      @(negedge clk);
      check("ready0", {31'd0, r0}, {31'd0, e0});
      check("ready1", {31'd0, r1}, {31'd0, e1});
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      n_reset = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      @(posedge clk);
      #1;
      n_reset = 1'b1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last_a, last_b, cnt_a, cnt_b;
      n_reset = 1'b0; v0 = 1'b0; v1 = 1'b0; pv = 1'b0;
      s0 = 2'd0; d0 = 2'd0; s1 = 2'd0; d1 = 2'd0; alu_we = 1'b0; alu_sel = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_strobes", {27'd0, oin, o1n, o0n, w1n, w0n}, 32'h1f);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_grant", {31'd0, grant}, 0);
      check("rst_alu", {31'd0, alu_o}, 0);
      @(posedge clk);
      #1;
      n_reset = 1'b1;
      mon_en  = 1'b1;

      // Immediate -> reg0, held for two moves: ready at cycles 0 and 4.
      v0 = 1'b1; s0 = 2'd2; d0 = 2'd1;
      sb.push_back(mk(0, 2'd2, 2'd1));
      sb.push_back(mk(0, 2'd2, 2'd1));
      step(1, 0);
      repeat (3) step(0, 0);
      step(1, 0);
      v0 = 1'b0;
      repeat (4) step(0, 0);

      // Tie from reset: strict alternation 0,1,0,1.
      reset_dut();
      v0 = 1'b1; s0 = 2'd0; d0 = 2'd2;
      v1 = 1'b1; s1 = 2'd1; d1 = 2'd1;
      repeat (2) begin
         sb.push_back(mk(0, 2'd0, 2'd2));
         sb.push_back(mk(1, 2'd1, 2'd1));
      end
      for (int c = 0; c < 16; c++) step(c == 0 || c == 8, c == 4 || c == 12);
      v0 = 1'b0; v1 = 1'b0;
      repeat (4) step(0, 0);

      // No-source move: full timing, no strobes.
      v1 = 1'b1; s1 = 2'd3; d1 = 2'd3;
      sb.push_back(mk(1, 2'd3, 2'd3));
      step(0, 1);
      v1 = 1'b0;
      repeat (4) step(0, 0);

      // ALU select loaded during DRIVE; move timing unaffected.
      v0 = 1'b1; s0 = 2'd0; d0 = 2'd1;
      sb.push_back(mk(0, 2'd0, 2'd1));
      step(1, 0);
      v0 = 1'b0; alu_we = 1'b1; alu_sel = 1'b1;
      @(negedge clk);
      check("alu_pre", {31'd0, alu_o}, 0);
      @(posedge clk);
      #1;
      alu_we = 1'b0;
      @(negedge clk);
      check("alu_load1", {31'd0, alu_o}, 1);
      @(posedge clk);
      #1;
      repeat (2) step(0, 0);
      alu_we = 1'b1; alu_sel = 1'b0;
      @(posedge clk);
      #1;
      alu_we = 1'b1; alu_sel = 1'b1;
      @(negedge clk);
      check("alu_load0", {31'd0, alu_o}, 0);
      @(posedge clk);
      #1;
      alu_we = 1'b0;
      @(negedge clk);
      check("alu_load1b", {31'd0, alu_o}, 1);
      @(posedge clk);
      #1;
      n_reset = 1'b0; alu_we = 1'b1; alu_sel = 1'b1;
      @(posedge clk);
      #1;
      n_reset = 1'b1; alu_we = 1'b0;
      @(negedge clk);
      check("alu_rst", {31'd0, alu_o}, 0);
      @(posedge clk);
      #1;

      // Reset during WRITE: abandoned move, then the tie goes to requester 0.
      v0 = 1'b1; s0 = 2'd1; d0 = 2'd1;
      sb.push_back(mk(0, 2'd1, 2'd1));
      step(1, 0);
      v0 = 1'b0;
      step(0, 0);
      n_reset = 1'b0;
      v0 = 1'b1; s0 = 2'd0; d0 = 2'd2;
      v1 = 1'b1; s1 = 2'd1; d1 = 2'd1;
      step(0, 0);
      n_reset = 1'b1;
      sb.push_back(mk(0, 2'd0, 2'd2));
      sb.push_back(mk(1, 2'd1, 2'd1));
      step(1, 0);
      repeat (3) step(0, 0);
      step(0, 1);
      v0 = 1'b0; v1 = 1'b0;
      repeat (4) step(0, 0);

      // Accept period with TURN_CYCLES 0 and 3.
      pv = 1'b1;
      last_a = -1; last_b = -1; cnt_a = 0; cnt_b = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         check("t0_noe_excl", 32'($countones(~sa[4:2]) <= 1), 1);
         check("t3_noe_excl", 32'($countones(~sb_s[4:2]) <= 1), 1);
         if (ra) begin
            if (last_a >= 0) check("t0_period", c - last_a, 3);
            last_a = c;
            cnt_a++;
         end
         if (rb) begin
            if (last_b >= 0) check("t3_period", c - last_b, 6);
            last_b = c;
            cnt_b++;
         end
         @(posedge clk);
         #1;
      end
      pv = 1'b0;
      check("t0_accepts", cnt_a, 10);
      check("t3_accepts", cnt_b, 5);
      repeat (8) @(posedge clk);
      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/regset_bus_sequencer.md
Name: regset_bus_sequencer

Overview:
- Sequences transfers on the shared 8-bit bus for the two-register set and the immediate driver.
- Two requesters (e.g. the instruction decoder and the debug port) submit src→dst moves through a valid/ready handshake; the block arbitrates between them round-robin.
- Drives the set's active-low write/output-enable strobes and the registered ALU-operand select.
- Guarantees at most one bus driver at any time and a configurable turnaround gap between transfers.

Parameters:
- TURN_CYCLES, 1, idle cycles with all strobes high after each WRITE; legal 0..3.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_nReset  in  1  synchronous reset, active low.
- i_req0Valid  in  1  requester 0 has a transfer pending.
- i_req0Src  in  2  source: 0=reg0, 1=reg1, 2=immediate, 3=none.
- i_req0Dst  in  2  destination mask: bit0=reg0, bit1=reg1.
- o_req0Ready  out  1  requester 0 transfer accepted this cycle.
- i_req1Valid, i_req1Src, i_req1Dst, o_req1Ready: same as requester 0.
- i_aluSelWe  in  1  load i_aluSel this cycle.
- i_aluSel  in  1  new ALU operand select.
- o_ctrlReg0NWE  out  1  reg0 write enable, active low.
- o_ctrlReg1NWE  out  1  reg1 write enable, active low.
- o_ctrlReg0BusNOE  out  1  reg0 bus drive, active low.
- o_ctrlReg1BusNOE  out  1  reg1 bus drive, active low.
- o_ctrlImmBusNOE  out  1  immediate bus drive, active low.
- o_ctrlAluSel  out  1  ALU operand select.
- o_busy  out  1  high in any state other than IDLE.
- o_grant  out  1  index of the requester owning the current or last transfer.

Behaviour:
- Reset (i_nReset low at a posedge):
  - state=IDLE; all NWE/NOE=1; o_ctrlAluSel=0; o_busy=0; o_grant=0.
  - Round-robin pointer set so requester 0 wins the first tie.
  - Reset overrides every other input, including mid-transfer; an in-flight transfer is abandoned and no write strobe is issued afterwards.
- States: IDLE → DRIVE → WRITE → TURN (TURN_CYCLES cycles; skipped if 0) → IDLE.
- Arbitration and handshake (IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted last; pointer updates on accept.
  - o_reqNReady = (state==IDLE) & granted & i_reqNValid; combinational, and never high for both requesters.
  - Accept = valid & ready at a posedge: src/dst latched, o_grant updated, next state DRIVE.
  - Requesters hold valid/src/dst stable until ready; dropping valid before ready is permitted and means no transfer.
- DRIVE (1 cycle): NOE of the latched src low (src=3: none); all NWE high.
- WRITE (1 cycle): src NOE stays low; NWE low for each set dst bit. The destination register captures at the posedge ending WRITE.
  - Src=3 or dst=0 → no NWE asserted (no-op that still takes full timing).
  - Src equal to dst is legal (rewrite).
- TURN: all strobes high.
- Every strobe output comes straight from a flop; no glitches, no cycle with two NOE low.
- Latency: accept edge → DRIVE in the next cycle → write edge at the end of cycle 2 after accept. Back-to-back period = 3+TURN_CYCLES cycles.
- ALU select:
  - i_aluSelWe at a posedge → o_ctrlAluSel=i_aluSel next cycle, in any state; independent of transfers.
  - Simultaneous with reset: reset wins.
- Inputs seen outside IDLE are ignored; ready stays low.

Test Plan:
- Reset, then req0 valid, src=2, dst=01 → ready0 high cycle 0; ImmNOE low cycles 1-2; Reg0NWE low cycle 2 only; busy cycles 1-3 (TURN_CYCLES=1); ready again cycle 4.
- Both valid from reset (req0 src=0 dst=10, req1 src=1 dst=01) → req0 granted first, req1 accepted 4 cycles later; o_grant 0 then 1. Hold both valid for 4 transfers → strict alternation 0,1,0,1.
- req1 src=3 dst=11 → full DRIVE/WRITE timing, no NOE or NWE ever low, busy for 3 cycles.
- Reset pulsed in the WRITE cycle of a transfer → next cycle all strobes 1, state IDLE; the next tie is granted to requester 0.
- i_aluSelWe=1, i_aluSel=1 during a DRIVE → o_ctrlAluSel=1 next cycle, transfer timing unchanged; reset → 0.
- TURN_CYCLES=0 and TURN_CYCLES=3 builds, continuous requests → accept period 3 and 6 cycles respectively. A check on every cycle confirms no two NOE low together.
